// File: rtl/conv1_feeder_if.sv
// conv1_feeder bus: frame-memory write port, stream control and pixel output.
// master = host/DMA side, slave = conv1_feeder.
interface conv1_feeder_if #(
   parameter int DATA_BITS = 32,
   parameter int AW        = 10
);
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [DATA_BITS-1:0] wr_data;
   logic                 swap;
   logic                 start;
   logic                 valid_out;
   logic [DATA_BITS-1:0] data_out;
   logic                 busy;
   logic                 done;
   logic [15:0]          frame_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, swap, start,
      input  valid_out, data_out, busy, done, frame_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, swap, start,
      output valid_out, data_out, busy, done, frame_cnt
   );
endinterface

// File: rtl/conv1_feeder.sv
// Frame streamer for the conv1 window buffer: raster stream, zero tail, gap.
// Ports: clk, rst (sync, active-high), bus (conv1_feeder_if.slave).
// Optional macro CONV1_FEEDER_PINGPONG_EN: two-bank memory with swap.
module conv1_feeder #(
   parameter int WIDTH       = 28,
   parameter int HEIGHT      = 36,
   parameter int DATA_BITS   = 32,
   parameter int TAIL_CYCLES = 28,
   parameter int GAP_CYCLES  = 1
) (
   input logic            clk,
   input logic            rst,
   conv1_feeder_if.slave  bus
);
   localparam int PIX = WIDTH * HEIGHT;
   localparam int AW  = $clog2(PIX);
`ifdef CONV1_FEEDER_PINGPONG_EN
   localparam int NB  = 2;
`else
   localparam int NB  = 1;
`endif
   localparam int IW  = $clog2(NB * PIX);

   localparam logic [AW-1:0] LAST      = AW'(PIX - 1);
   localparam logic [15:0]   TAIL_LAST = 16'(TAIL_CYCLES - 1);
   localparam logic [15:0]   GAP_END   = 16'(GAP_CYCLES);

   typedef enum logic [1:0] {IDLE, STREAM, TAIL, GAP} state_t;

   state_t               state;
   logic [AW-1:0]        rd_addr;
   logic [15:0]          cnt;
   logic                 valid_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 busy_q;
   logic                 done_q;
   logic [15:0]          frame_q;

   logic [DATA_BITS-1:0] mem [NB*PIX];
   logic [IW-1:0]        rd_idx;
   logic [IW-1:0]        wr_idx;
   logic                 in_range;
   logic                 wr_ok;

   assign in_range = {1'b0, bus.wr_addr} < (AW+1)'(PIX);

`ifdef CONV1_FEEDER_PINGPONG_EN
   logic bank;
   logic pend;

   // bank selects the front (read) half; writes always hit the other half
   assign rd_idx = bank ? IW'(PIX) + IW'(rd_addr) : IW'(rd_addr);
   assign wr_idx = bank ? IW'(bus.wr_addr) : IW'(PIX) + IW'(bus.wr_addr);
   assign wr_ok  = bus.wr_en & in_range;
`else
   logic unused_swap;

   assign unused_swap = bus.swap;
   assign rd_idx      = IW'(rd_addr);
   assign wr_idx      = IW'(bus.wr_addr);
   assign wr_ok       = bus.wr_en & in_range & ~busy_q;
`endif

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_idx] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rd_addr <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         frame_q <= '0;
`ifdef CONV1_FEEDER_PINGPONG_EN
         pend    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef CONV1_FEEDER_PINGPONG_EN
         if (bus.swap && state != IDLE)
            pend <= 1'b1;
`endif
         unique case (state)
            IDLE: begin
               valid_q <= 1'b0;
               data_q  <= '0;
`ifdef CONV1_FEEDER_PINGPONG_EN
               if (bus.swap)
                  bank <= ~bank;
`endif
               if (bus.start) begin
                  state   <= STREAM;
                  busy_q  <= 1'b1;
                  rd_addr <= '0;
               end
            end
            STREAM: begin
               valid_q <= 1'b1;
               data_q  <= mem[rd_idx];
               rd_addr <= rd_addr + AW'(1);
               if (rd_addr == LAST) begin
                  cnt   <= '0;
                  state <= (TAIL_CYCLES == 0) ? GAP : TAIL;
               end
            end
            TAIL: begin
               valid_q <= 1'b1;
               data_q  <= '0;
               cnt     <= cnt + 16'd1;
               if (cnt == TAIL_LAST) begin
                  cnt   <= '0;
                  state <= GAP;
               end
            end
            GAP: begin
               valid_q <= 1'b0;
               data_q  <= '0;
               cnt     <= cnt + 16'd1;
               // the final gap edge is IDLE entry: done, count, swap,
               // and a held start is taken here so back-to-back
               // frames see only GAP_CYCLES+1 valid-low cycles
               if (cnt == GAP_END) begin
                  done_q  <= 1'b1;
                  frame_q <= frame_q + 16'd1;
`ifdef CONV1_FEEDER_PINGPONG_EN
                  if (pend || bus.swap)
                     bank <= ~bank;
                  pend <= 1'b0;
`endif
                  if (bus.start) begin
                     state   <= STREAM;
                     rd_addr <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign bus.valid_out = valid_q;
   assign bus.data_out  = data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.frame_cnt = frame_q;
endmodule

// File: tb/tb_conv1_feeder.sv
// Directed testbench for conv1_feeder (28x36 frame, tail 28, gap 1).
// Drives the interface master side; checks stream, tail, gap, done, resets.
module tb_conv1_feeder;
   localparam int W    = 28;
   localparam int H    = 36;
   localparam int P    = W * H;
   localparam int AW   = 10;
   localparam int DB   = 32;
   localparam int TAIL = 28;
   localparam int GAP  = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   conv1_feeder_if #(.DATA_BITS(DB), .AW(AW)) bus ();

   conv1_feeder #(
      .WIDTH(W), .HEIGHT(H), .DATA_BITS(DB),
      .TAIL_CYCLES(TAIL), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] front_base = 32'h0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams one frame from start and counts beats that deviate from
   // base+k pixels, zero tail, gap beat(s) and the done cycle.
   task automatic run_frame(input logic [31:0] base, output int bad);
      bad = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (bus.busy !== 1'b1 || bus.valid_out !== 1'b0) bad++;
      for (int k = 0; k < P; k++) begin
         tick();
         if (bus.valid_out !== 1'b1 || bus.data_out !== base + 32'(k)) bad++;
      end
      for (int t = 0; t < TAIL; t++) begin
         tick();
         if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h0) bad++;
      end
      for (int g = 0; g < GAP; g++) begin
         tick();
         if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1 ||
             bus.done !== 1'b0 || bus.data_out !== 32'h0) bad++;
      end
      tick();
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.valid_out !== 1'b0)
         bad++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%0b want=0", bus.valid_out);
      end
      checks++;
      if (bus.data_out !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got=%h want=0", bus.data_out);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%0b want=0", bus.busy);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%0b want=0", bus.done);
      end
      checks++;
      if (bus.frame_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_frame_cnt got=%0d want=0", bus.frame_cnt);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic load_frame(input logic [31:0] base);
      for (int i = 0; i < P; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = AW'(i);
         bus.wr_data = base + 32'(i);
         tick();
      end
      bus.wr_en = 1'b0;
`ifdef CONV1_FEEDER_PINGPONG_EN
      bus.swap = 1'b1;
      tick();
      bus.swap = 1'b0;
`endif
      front_base = base;
   endtask

   task automatic test_single_frame();
      int bad;
      run_frame(front_base, bad);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL single_frame bad_beats=%0d want=0", bad);
      end
      checks++;
      if (bus.frame_cnt !== 16'd1) begin
         failures++;
         $display("FAIL single_frame_cnt got=%0d want=1", bus.frame_cnt);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL done_one_cycle got=%0b want=0", bus.done);
      end
   endtask

   task automatic test_oob_write();
      int bad;
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(P);
      bus.wr_data = 32'hDEADBEEF;
      tick();
      bus.wr_en = 1'b0;
      run_frame(front_base, bad);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL oob_write bad_beats=%0d want=0", bad);
      end
      checks++;
      if (bus.frame_cnt !== 16'd2) begin
         failures++;
         $display("FAIL oob_frame_cnt got=%0d want=2", bus.frame_cnt);
      end
   endtask

`ifndef CONV1_FEEDER_PINGPONG_EN
   task automatic test_busy_write();
      int bad1;
      int bad2;
      fork
         run_frame(front_base, bad1);
         begin
            repeat (5) tick();
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(10);
            bus.wr_data = 32'h0000FFFF;
            tick();
            bus.wr_en = 1'b0;
         end
      join
      checks++;
      if (bad1 !== 0) begin
         failures++;
         $display("FAIL busy_write_frame1 bad_beats=%0d want=0", bad1);
      end
      run_frame(front_base, bad2);
      checks++;
      if (bad2 !== 0) begin
         failures++;
         $display("FAIL busy_write_dropped bad_beats=%0d want=0", bad2);
      end
   endtask
`else
   task automatic test_pingpong();
      int bad1;
      int bad2;
      fork
         run_frame(front_base, bad1);
         begin
            for (int i = 0; i < P; i++) begin
               bus.wr_en   = 1'b1;
               bus.wr_addr = AW'(i);
               bus.wr_data = 32'h1000 + 32'(i);
               bus.swap    = (i == 500);
               tick();
            end
            bus.wr_en = 1'b0;
            bus.swap  = 1'b0;
         end
      join
      checks++;
      if (bad1 !== 0) begin
         failures++;
         $display("FAIL pingpong_frame_a bad_beats=%0d want=0", bad1);
      end
      run_frame(32'h1000, bad2);
      checks++;
      if (bad2 !== 0) begin
         failures++;
         $display("FAIL pingpong_frame_b bad_beats=%0d want=0", bad2);
      end
      front_base = 32'h1000;
   endtask
`endif

   task automatic test_reset_mid();
      int bad;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k <= 500; k++) tick();
      checks++;
      if (bus.data_out !== front_base + 32'd500) begin
         failures++;
         $display("FAIL mid_pixel500 got=%h want=%h",
                  bus.data_out, front_base + 32'd500);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0 ||
          bus.data_out !== 32'h0 || bus.frame_cnt !== 16'd0) begin
         failures++;
         $display("FAIL mid_reset got v=%0b b=%0b d=%h n=%0d want 0/0/0/0",
                  bus.valid_out, bus.busy, bus.data_out, bus.frame_cnt);
      end
      tick();
      run_frame(front_base, bad);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL mid_reset_replay bad_beats=%0d want=0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int  high;
      int  low;
      int  starts;
      int  dones;
      int  cyc;
      logic prev;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b1;
      tick();
      high   = 0;
      low    = 1;
      starts = 0;
      dones  = 0;
      cyc    = 0;
      prev   = 1'b0;
      while (bus.frame_cnt !== 16'd3 && cyc < 5000) begin
         tick();
         cyc++;
         if (bus.done === 1'b1) dones++;
         if (bus.valid_out === 1'b1) begin
            if (!prev) begin
               starts++;
               if (starts > 1) begin
                  checks++;
                  if (low !== GAP + 1) begin
                     failures++;
                     $display("FAIL b2b_gap got=%0d want=%0d", low, GAP + 1);
                  end
               end
               if (starts == 3) bus.start = 1'b0;
            end
            high++;
            low = 0;
         end else begin
            if (prev) begin
               checks++;
               if (high !== P + TAIL) begin
                  failures++;
                  $display("FAIL b2b_run got=%0d want=%0d", high, P + TAIL);
               end
            end
            high = 0;
            low++;
         end
         prev = bus.valid_out;
      end
      bus.start = 1'b0;
      checks++;
      if (cyc >= 5000) begin
         failures++;
         $display("FAIL b2b_timeout got=%0d want<5000", cyc);
      end
      checks++;
      if (bus.frame_cnt !== 16'd3 || dones !== 3) begin
         failures++;
         $display("FAIL b2b_frames got cnt=%0d dones=%0d want=3/3",
                  bus.frame_cnt, dones);
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.swap    = 1'b0;
      bus.start   = 1'b0;
      test_reset();
      load_frame(32'h0);
      test_single_frame();
      test_oob_write();
`ifndef CONV1_FEEDER_PINGPONG_EN
      test_busy_write();
`else
      test_pingpong();
`endif
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv1_feeder.md
# conv1_feeder

Frame streamer that drives the pixel input of the conv1 window buffer. A host or DMA loads a WIDTH×HEIGHT frame into on-chip memory through a write port. On `start`, the block streams the frame in raster order with valid held high without a break, because the window buffer restarts on any valid drop. It then pads zeros so the window buffer can drain, and forces a valid-low gap before the next frame.

## Interface
- `WIDTH`, 28, frame width in pixels
- `HEIGHT`, 36, frame height in pixels
- `DATA_BITS`, 32, pixel width
- `TAIL_CYCLES`, 28, zero-pad beats appended after the last pixel with valid still high; 0 is legal
- `GAP_CYCLES`, 1, valid-low cycles forced after each frame; minimum 1
- `clk` in 1: clock; all logic on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `wr_en` in 1: frame memory write strobe
- `wr_addr` in AW = $clog2(WIDTH*HEIGHT): raster pixel address
- `wr_data` in DATA_BITS: pixel to store
- `swap` in 1: exchange front and back banks (PINGPONG builds only)
- `start` in 1: request streaming of the front bank
- `valid_out` in the sink's terms, out 1: drives the window buffer's `valid_in`
- `data_out` out DATA_BITS: drives the window buffer's `data_in`
- `busy` out 1: frame in progress, from `start` acceptance until the end of the gap
- `done` out 1: one-cycle pulse at frame completion
- `frame_cnt` out 16: completed frames; wraps at 65535→0

## Operation
- States:
  - IDLE
  - STREAM: pixels 0..W*H-1
  - TAIL: TAIL_CYCLES zero beats
  - GAP: GAP_CYCLES idle beats
  - back to IDLE
- Transitions:
  - IDLE→STREAM on `start`=1 sampled in IDLE.
  - STREAM→TAIL after the last read is issued; skip directly to GAP if TAIL_CYCLES=0.
  - TAIL→GAP when the tail counter expires.
  - GAP→IDLE when the gap counter expires.
- `start` outside IDLE is ignored. It is not queued.
- Read address counter is AW bits. It counts 0..W*H-1 and never wraps within a frame.
- Memory read is synchronous (one-cycle), and `data_out`/`valid_out` are registered.
- `valid_out`=1 in STREAM output beats and TAIL beats only. `data_out`=0 during TAIL and whenever `valid_out`=0.
- Writes with `wr_addr` ≥ W*H are dropped.
- Write to the bank currently being read: dropped (single-bank build: all writes while `busy`=1 are dropped).
- `done` rises on the cycle IDLE is re-entered. `frame_cnt` increments on the same edge.
- Reset mid-frame:
  - next cycle: IDLE, all outputs at reset values, pending swap cleared.
  - memory contents and bank select are preserved.
- Reset values: `valid_out`=0, `data_out`=0, `busy`=0, `done`=0, `frame_cnt`=0.

## Timing
- `start` sampled at edge N → `busy`=1 after edge N.
- Pixel k is presented with `valid_out`=1 after edge N+1+k. The first pixel appears 1 cycle after acceptance.
- Last pixel is after edge N+W*H. Tail beats follow at N+W*H+1 .. N+W*H+TAIL_CYCLES.
- `valid_out`=0 for exactly GAP_CYCLES cycles. `done`=1 and `busy`=0 on the following cycle.
- Back-to-back: `start` held high streams a new frame with exactly GAP_CYCLES+1 valid-low cycles between frames. One of those cycles is the IDLE/`done` cycle.
- Write: `wr_en` at edge M makes the data readable from edge M+1.

## Configuration
- `CONV1_FEEDER_PINGPONG_EN` defined: two banks of W*H words.
  - `wr_*` always targets the back bank, including while busy.
  - `swap` in IDLE flips banks on that edge.
  - `swap` while busy is latched and applied on IDLE entry.
  - `swap` and `start` together in IDLE: swap first, and the newly-front bank streams.
- Not defined: one bank.
  - `swap` port is present but ignored.
  - Writes are accepted only while `busy`=0.

## Test plan
- Load pixel[i]=i for a 28×36 frame, pulse `start` → 1008 consecutive valid beats with data 0..1007, then 28 zero beats, 1 valid-low beat, then `done` pulse; `frame_cnt`=1.
- Hold `start` high for 3 frames → valid never drops mid-frame; each inter-frame gap has exactly 2 valid-low cycles; `frame_cnt`=3.
- Assert `rst` at pixel 500 → next cycle `valid_out`=0, `busy`=0, `data_out`=0. A new `start` replays from pixel 0 with unchanged data.
- `wr_addr`=1008 with data 0xDEADBEEF, then a full stream → the value never appears on `data_out`; pixels 0..1007 are unaltered.
- PINGPONG: stream bank A (data i) while loading bank B with data 0x1000+i, and pulse `swap` mid-frame → frame 1 is all i; next `start` gives 0x1000+i.
- Non-PINGPONG: write pixel 10 with 0xFFFF while busy → write dropped; the next frame still shows 10 at pixel 10.
